// File: rtl/amm_burst_arbiter.sv
// amm_burst_arbiter: two-master Avalon-MM burst arbiter, in-order read routing.
// Define AMM_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins contests).
module amm_burst_arbiter #(
  parameter int ADDR_W         = 31,
  parameter int DATA_W         = 128,
  parameter int BURST_W        = 11,
  parameter int RSP_FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [1:0]            m_read_i,
  input  logic [1:0]            m_write_i,
  input  logic [2*ADDR_W-1:0]   m_address_i,
  input  logic [2*DATA_W-1:0]   m_writedata_i,
  input  logic [2*DATA_W/8-1:0] m_byteenable_i,
  input  logic [2*BURST_W-1:0]  m_burstcount_i,
  output logic [1:0]            m_waitrequest_o,
  output logic [1:0]            m_readdatavalid_o,
  output logic [DATA_W-1:0]     m_readdata_o,
  output logic [ADDR_W-1:0]     s_address_o,
  output logic                  s_read_o,
  output logic                  s_write_o,
  output logic [DATA_W-1:0]     s_writedata_o,
  output logic [DATA_W/8-1:0]   s_byteenable_o,
  output logic [BURST_W-1:0]    s_burstcount_o,
  input  logic                  s_waitrequest_i,
  input  logic                  s_readdatavalid_i,
  input  logic [DATA_W-1:0]     s_readdata_i,
  output logic                  orphan_rsp_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT =
    (PTR_W+1)'(RSP_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_RD,
    GRANT_WR
  } state_t;

  state_t             state;
  logic               gnt;
  logic               wr_started;
  logic [BURST_W-1:0] beat_cnt;
`ifndef AMM_ARB_FIXED_PRIO_EN
  logic               last_gnt;
`endif

  logic               fifo_id [RSP_FIFO_DEPTH];
  logic [BURST_W-1:0] fifo_bc [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [BURST_W-1:0] head_beats;
  logic               orphan_q;

  logic               full;
  logic               empty;
  logic [1:0]         elig;
  logic               win;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [BE_W-1:0]    g_be;
  logic [BURST_W-1:0] g_bc;
  logic [BURST_W-1:0] g_bc_m1;
  logic               wr_acc;
  logic               push;
  logic               head_id;
  logic [BURST_W-1:0] head_bc;
  logic               head_last;
  logic               rsp_hit;
  logic               pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign elig  = m_write_i | (m_read_i & {2{~full}});

`ifdef AMM_ARB_FIXED_PRIO_EN
  assign win = ~elig[0];
`else
  assign win = (&elig) ? ~last_gnt : elig[1];
`endif

  assign g_addr  = gnt ? m_address_i[ADDR_W +: ADDR_W]
                       : m_address_i[0 +: ADDR_W];
  assign g_wdata = gnt ? m_writedata_i[DATA_W +: DATA_W]
                       : m_writedata_i[0 +: DATA_W];
  assign g_be    = gnt ? m_byteenable_i[BE_W +: BE_W]
                       : m_byteenable_i[0 +: BE_W];
  assign g_bc    = gnt ? m_burstcount_i[BURST_W +: BURST_W]
                       : m_burstcount_i[0 +: BURST_W];
  // A burstcount of 0 behaves as a single beat.
  assign g_bc_m1 = (g_bc == '0) ? '0 : g_bc - BURST_W'(1);

  // Granted master's command drives the slave; idle keeps it quiet.
  always_comb begin
    s_address_o     = '0;
    s_writedata_o   = '0;
    s_byteenable_o  = '0;
    s_burstcount_o  = '0;
    s_read_o        = 1'b0;
    s_write_o       = 1'b0;
    m_waitrequest_o = 2'b11;
    if (state != IDLE) begin
      s_address_o          = g_addr;
      s_writedata_o        = g_wdata;
      s_byteenable_o       = g_be;
      s_burstcount_o       = g_bc;
      m_waitrequest_o[gnt] = s_waitrequest_i;
    end
    s_read_o  = (state == GRANT_RD) & m_read_i[gnt];
    s_write_o = (state == GRANT_WR) & m_write_i[gnt];
  end

  assign wr_acc = s_write_o & ~s_waitrequest_i;
  assign push   = s_read_o & ~s_waitrequest_i;

  assign head_id   = fifo_id[rd_ptr];
  assign head_bc   = fifo_bc[rd_ptr];
  assign head_last = (head_bc == '0) ? 1'b1
                   : (head_beats == head_bc - BURST_W'(1));
  assign rsp_hit   = s_readdatavalid_i & ~empty;
  assign pop       = rsp_hit & head_last;

  assign m_readdatavalid_o = {rsp_hit & head_id, rsp_hit & ~head_id};
  assign m_readdata_o      = s_readdata_i;
  assign orphan_rsp_o      = orphan_q;

  // Arbitration and burst lock; a write burst holds the grant to the end.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      wr_started <= 1'b0;
      beat_cnt   <= '0;
`ifndef AMM_ARB_FIXED_PRIO_EN
      last_gnt   <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|elig) begin
            gnt        <= win;
            wr_started <= 1'b0;
`ifndef AMM_ARB_FIXED_PRIO_EN
            last_gnt   <= win;
`endif
            state <= m_write_i[win] ? GRANT_WR : GRANT_RD;
          end
        end
        GRANT_RD: begin
          if (!m_read_i[gnt] || !s_waitrequest_i)
            state <= IDLE;
        end
        GRANT_WR: begin
          if (wr_acc) begin
            if (!wr_started) begin
              if (g_bc_m1 == '0) begin
                state <= IDLE;
              end else begin
                beat_cnt   <= g_bc_m1;
                wr_started <= 1'b1;
              end
            end else if (beat_cnt == BURST_W'(1)) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt - BURST_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding read storage; contents are qualified by count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id[wr_ptr] <= gnt;
      fifo_bc[wr_ptr] <= g_bc;
    end
  end

  // Read tracking pointers, occupancy and head beat progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_beats <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        head_beats <= '0;
      end else if (rsp_hit) begin
        head_beats <= head_beats + BURST_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for read data that nobody asked for.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      orphan_q <= 1'b0;
    else if (s_readdatavalid_i && empty)
      orphan_q <= 1'b1;
  end

endmodule
